conv_interleaver_gen: RTL

- Parametrised convolutional (Forney) interleaver/deinterleaver for the byte-stream transport path, e.g. DVB I=12, M=17, 204-byte packets.
- Selectable per-packet mode: bypass, interleave or deinterleave.
- Ready/accept handshake on both sides; sits between the input packet framer and the outer coder/output stage.
- Adds sync-byte checking and an output start-of-packet marker.

---
 rtl/conv_interleaver_gen_if.sv | 15 +
 rtl/conv_interleaver_gen.sv | 121 ++++++++++++
 2 files changed

// File: rtl/conv_interleaver_gen_if.sv
// rtl/conv_interleaver_gen_if.sv - symbol stream handshake bundle for conv_interleaver_gen
interface conv_interleaver_gen_if #(
  parameter int DATA_W = 8
);
  logic              di_rdy;
  logic              di_acpt;
  logic [DATA_W-1:0] di;
  logic              do_rdy;
  logic              do_acpt;
  logic [DATA_W-1:0] do_data;
  logic              do_sop;

  modport slave  (input  di_rdy, di, do_acpt, output di_acpt, do_rdy, do_data, do_sop);
  modport master (output di_rdy, di, do_acpt, input  di_acpt, do_rdy, do_data, do_sop);
endinterface

// File: rtl/conv_interleaver_gen.sv
// rtl/conv_interleaver_gen.sv - Forney convolutional interleaver/deinterleaver with per-packet mode
// Branch FIFOs share one RAM; each delay slot k owns k*UNIT_DEPTH words starting at its base.
module conv_interleaver_gen #(
  parameter int                DATA_W     = 8,
  parameter int                BRANCHES   = 12,
  parameter int                UNIT_DEPTH = 17,
  parameter int                PKT_LEN    = 204,
  parameter logic [DATA_W-1:0] SYNC       = DATA_W'(8'h47),
  parameter logic [DATA_W-1:0] SYNC_INV   = DATA_W'(8'hB8)
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic [1:0]                   mode,
  conv_interleaver_gen_if.slave        bus,
  output logic                         sync_err
);
  localparam int RAM_DEPTH = UNIT_DEPTH * BRANCHES * (BRANCHES - 1) / 2;
  localparam int ADDR_W    = $clog2(RAM_DEPTH + 1);
  localparam int PTR_W     = $clog2((BRANCHES - 1) * UNIT_DEPTH + 1);
  localparam int BR_W      = $clog2(BRANCHES);
  localparam int CNT_W     = $clog2(PKT_LEN);
  localparam logic [BR_W-1:0]  LAST_BR  = BR_W'(BRANCHES - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(PKT_LEN - 1);

  generate
    if (BRANCHES < 2 || (PKT_LEN % BRANCHES) != 0) begin : g_bad_params
      $error("conv_interleaver_gen: PKT_LEN must be a multiple of BRANCHES and BRANCHES >= 2");
    end
  endgenerate

  typedef enum logic [1:0] {
    MODE_BYPASS  = 2'd0,
    MODE_INTLV   = 2'd1,
    MODE_DEINTLV = 2'd2
  } mode_t;

  mode_t             act_mode, mode_in, cur_mode;
  logic [CNT_W-1:0]  pkt_cnt;
  logic [BR_W-1:0]   br_ptr, slot;
  logic [PTR_W-1:0]  wr_ptr [BRANCHES];
  logic [BRANCHES-1:0] filled;
  logic [DATA_W-1:0] ram [RAM_DEPTH];
  logic              in_hs, pkt_start, mode_clear, cur_fill, wrap;
  logic [PTR_W-1:0]  cur_ptr, last_ptr;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] pop_data;
  logic              do_rdy_q, do_sop_q;
  logic [DATA_W-1:0] do_data_q;

  function automatic logic [ADDR_W-1:0] slot_base(input logic [BR_W-1:0] k);
    return ADDR_W'(UNIT_DEPTH * int'(k) * (int'(k) - 1) / 2);
  endfunction

  assign bus.do_rdy  = do_rdy_q;
  assign bus.do_data = do_data_q;
  assign bus.do_sop  = do_sop_q;
  assign bus.di_acpt = reset_n & (~do_rdy_q | bus.do_acpt);
  assign in_hs       = bus.di_rdy & bus.di_acpt;

  // A mode change at packet start behaves as if all slots were already emptied this cycle.
  always_comb begin
    mode_in = MODE_BYPASS;
    case (mode)
      2'd1:    mode_in = MODE_INTLV;
      2'd2:    mode_in = MODE_DEINTLV;
      default: mode_in = MODE_BYPASS;
    endcase
    pkt_start  = (pkt_cnt == '0);
    cur_mode   = pkt_start ? mode_in : act_mode;
    mode_clear = in_hs & pkt_start & (mode_in != act_mode);
    case (cur_mode)
      MODE_INTLV:   slot = br_ptr;
      MODE_DEINTLV: slot = LAST_BR - br_ptr;
      default:      slot = '0;
    endcase
    cur_ptr  = mode_clear ? '0 : wr_ptr[slot];
    cur_fill = ~mode_clear & filled[slot];
    last_ptr = PTR_W'(int'(slot) * UNIT_DEPTH - 1);
    wrap     = (cur_ptr == last_ptr);
    ram_addr = slot_base(slot) + ADDR_W'(cur_ptr);
    pop_data = (slot == '0) ? bus.di : (cur_fill ? ram[ram_addr] : '0);
  end

  always_ff @(posedge clk) begin
    if (in_hs && slot != '0) ram[ram_addr] <= bus.di;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pkt_cnt   <= '0;
      br_ptr    <= '0;
      act_mode  <= MODE_BYPASS;
      filled    <= '0;
      for (int k = 0; k < BRANCHES; k++) wr_ptr[k] <= '0;
      do_rdy_q  <= 1'b0;
      do_data_q <= '0;
      do_sop_q  <= 1'b0;
      sync_err  <= 1'b0;
    end else begin
      sync_err <= in_hs & pkt_start & (bus.di != SYNC) & (bus.di != SYNC_INV);
      if (in_hs) begin
        pkt_cnt  <= (pkt_cnt == LAST_CNT) ? '0 : pkt_cnt + 1'b1;
        br_ptr   <= (br_ptr == LAST_BR || pkt_cnt == LAST_CNT) ? '0 : br_ptr + 1'b1;
        act_mode <= cur_mode;
        if (mode_clear) begin
          filled <= '0;
          for (int k = 0; k < BRANCHES; k++) wr_ptr[k] <= '0;
        end
        if (slot != '0) begin
          wr_ptr[slot] <= wrap ? '0 : cur_ptr + 1'b1;
          if (wrap) filled[slot] <= 1'b1;
        end
        do_rdy_q  <= 1'b1;
        do_data_q <= pop_data;
        do_sop_q  <= pkt_start;
      end else if (bus.do_acpt) begin
        do_rdy_q <= 1'b0;
      end
    end
  end
endmodule
